wb_ctrl_pipe: RTL and testbench
===============================

WB_CTRL_PIPE -- requirements
Module: wb_ctrl_pipe

Interface
REQ-001 Parameter DEPTH, default 2, pipeline stages between decode and writeback outputs; legal range 1..4.
REQ-002 Parameter CSR_EN, default 1, enables CSR write decode; 0 forces csr_we low and treats SYSTEM as illegal.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  upstream instruction fields valid.
REQ-006 in_ready  output  1  block accepts instruction this cycle; accept = in_valid & in_ready.
REQ-007 stall  input  1  downstream hold; freezes every stage.
REQ-008 flush  input  1  kills all in-flight entries.
REQ-009 opcode / funct3 / rd / rs1 / rs2  input  7/3/5/5/5  instruction fields.
REQ-010 wb_valid  output  1  final-stage entry valid.
REQ-011 wb_sel  output  2  writeback mux select: 0 MEM, 1 ALU, 2 PC+4.
REQ-012 rwe / csr_we / illegal  output  1 each  regfile write, CSR write, unsupported opcode.
REQ-013 wb_rd  output  5  destination register; ld_size 2 bits (0 byte, 1 half, 2 word); ld_unsigned 1 bit.
REQ-014 hazard  output  1  load-use conflict on current input.

Function
REQ-015 Decode: LOAD -> wb_sel MEM, rwe 1; OP, OP-IMM, LUI, AUIPC -> ALU, rwe 1; JAL, JALR -> PC+4, rwe 1.
REQ-016 Decode: BRANCH, STORE -> rwe 0, wb_sel ALU; SYSTEM with funct3 001 or 101 -> csr_we 1, rwe 0, wb_sel ALU.
REQ-017 Any other opcode/funct3 combination -> rwe 0, csr_we 0, wb_sel ALU, illegal 1.
REQ-018 rwe forced 0 when rd == 0, regardless of opcode.
REQ-019 ld_size = funct3[1:0], ld_unsigned = funct3[2], for LOAD only; both 0 otherwise.
REQ-020 hazard = in_valid & (any valid in-flight LOAD entry with rd != 0 matching rs1 or rs2); rs2 always compared.
REQ-021 in_ready = ~stall & ~hazard & ~flush.
REQ-022 stall = 1: all stages hold contents; outputs stable.
REQ-023 stall = 0, accept = 1: stage 0 loads decoded fields with valid 1; each stage k shifts to k+1.
REQ-024 stall = 0, accept = 0: stage 0 loads a bubble (valid 0); remaining stages shift.
REQ-025 flush has priority over stall: next edge clears every stage valid bit; fields may be retained.
REQ-026 Latency: an accepted instruction appears at wb_* exactly DEPTH unstalled cycles after acceptance.
REQ-027 When wb_valid = 0: rwe, csr_we, illegal, ld_unsigned driven 0; wb_sel, wb_rd, ld_size driven 0.
REQ-028 Outputs are registered from the final stage; no combinational path from inputs to wb_* outputs.

Reset
REQ-029 reset_n low asynchronously clears all stage valid bits and drives every output to 0 (in_ready and hazard then follow inputs combinationally).
REQ-030 Reset asserted mid-operation discards all in-flight entries; no write enable pulses after release without a new acceptance.

Structure
REQ-031 Package wb_ctrl_pkg holds opcode constants, WB_SEL_MEM/ALU/PC4 encodings, CSRRW/CSRRWI funct3 codes, ld_size encodings, stage-entry field widths.
REQ-032 One combinational sub-module wb_ctrl_decode (opcode, funct3, rd -> wb_sel, rwe, csr_we, illegal, ld_size, ld_unsigned), instantiated once before stage 0.
REQ-033 Stage storage is a generate-loop array sized by DEPTH; no per-DEPTH special-case code.

Verification
REQ-034 DEPTH=2: accept LOAD rd=5 funct3=100 -> two cycles later wb_valid 1, wb_sel 0, rwe 1, wb_rd 5, ld_size 0, ld_unsigned 1.
REQ-035 LOAD rd=7 accepted, next cycle OP rs1=7 -> hazard 1, in_ready 0, bubble inserted; after load leaves pipeline, OP accepted.
REQ-036 OP-IMM rd=0 and SYSTEM funct3=001 -> rwe 0 for both; csr_we 1 for SYSTEM only; CSR_EN=0 -> illegal 1, csr_we 0.
REQ-037 stall held 3 cycles with full pipeline -> wb_* unchanged for 3 cycles; flush asserted with stall -> wb_valid 0 next cycle.
REQ-038 Opcode 1111111 -> illegal 1, rwe 0; reset_n pulsed low mid-stream -> all outputs 0 immediately, no stale wb_valid after release.
REQ-039 Sweep DEPTH = 1, 2, 4 with a random 200-instruction stream against a behavioural delay-line model; all outputs match.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared encodings and stage-entry layout for the writeback control pipeline.
package wb_ctrl_pkg;

    localparam int OPC_W = 7;
    localparam int F3_W  = 3;
    localparam int REG_W = 5;
    localparam int SEL_W = 2;
    localparam int LSZ_W = 2;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [SEL_W-1:0] WB_SEL_MEM = 2'd0;
    localparam logic [SEL_W-1:0] WB_SEL_ALU = 2'd1;
    localparam logic [SEL_W-1:0] WB_SEL_PC4 = 2'd2;

    localparam logic [F3_W-1:0] F3_CSRRW  = 3'b001;
    localparam logic [F3_W-1:0] F3_CSRRWI = 3'b101;

    localparam logic [LSZ_W-1:0] LD_SIZE_B = 2'd0;
    localparam logic [LSZ_W-1:0] LD_SIZE_H = 2'd1;
    localparam logic [LSZ_W-1:0] LD_SIZE_W = 2'd2;

    typedef struct packed {
        logic [SEL_W-1:0] wb_sel;
        logic             rwe;
        logic             csr_we;
        logic             illegal;
        logic [REG_W-1:0] rd;
        logic [LSZ_W-1:0] ld_size;
        logic             ld_unsigned;
    } stage_ent_t;

endpackage

// File: rtl/wb_ctrl_decode.sv
// Combinational decode of opcode/funct3/rd into writeback control fields.
module wb_ctrl_decode
    import wb_ctrl_pkg::*;
#(
    parameter int CSR_EN = 1
) (
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic [REG_W-1:0] rd,
    output logic [SEL_W-1:0] wb_sel,
    output logic             rwe,
    output logic             csr_we,
    output logic             illegal,
    output logic [LSZ_W-1:0] ld_size,
    output logic             ld_unsigned
);

    always_comb begin
        wb_sel      = WB_SEL_ALU;
        rwe         = 1'b0;
        csr_we      = 1'b0;
        illegal     = 1'b0;
        ld_size     = LD_SIZE_B;
        ld_unsigned = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                wb_sel      = WB_SEL_MEM;
                rwe         = 1'b1;
                ld_size     = funct3[1:0];
                ld_unsigned = funct3[2];
            end
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: rwe = 1'b1;
            OPC_JAL, OPC_JALR: begin
                wb_sel = WB_SEL_PC4;
                rwe    = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
            end
            OPC_SYSTEM: begin
                if (CSR_EN != 0 && (funct3 == F3_CSRRW || funct3 == F3_CSRRWI))
                    csr_we = 1'b1;
                else
                    illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        // x0 is hardwired, so no instruction may request a write to it
        if (rd == '0)
            rwe = 1'b0;
    end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// Writeback control pipeline: decode once, carry fields through DEPTH stages,
// detect load-use hazards against every in-flight load.
module wb_ctrl_pipe
    import wb_ctrl_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int CSR_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             stall,
    input  logic             flush,
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct3,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rs1,
    input  logic [REG_W-1:0] rs2,
    output logic             wb_valid,
    output logic [SEL_W-1:0] wb_sel,
    output logic             rwe,
    output logic             csr_we,
    output logic             illegal,
    output logic [REG_W-1:0] wb_rd,
    output logic [LSZ_W-1:0] ld_size,
    output logic             ld_unsigned,
    output logic             hazard
);

    logic [SEL_W-1:0] d_sel;
    logic             d_rwe;
    logic             d_csr;
    logic             d_ill;
    logic [LSZ_W-1:0] d_lsz;
    logic             d_lu;
    stage_ent_t       dec_ent;
    logic             accept;
    logic             ld_hit;

    logic       vld_p [DEPTH];
    stage_ent_t ent_p [DEPTH];

    wb_ctrl_decode #(.CSR_EN(CSR_EN)) u_decode (
        .opcode     (opcode),
        .funct3     (funct3),
        .rd         (rd),
        .wb_sel     (d_sel),
        .rwe        (d_rwe),
        .csr_we     (d_csr),
        .illegal    (d_ill),
        .ld_size    (d_lsz),
        .ld_unsigned(d_lu)
    );

    assign dec_ent = {d_sel, d_rwe, d_csr, d_ill, rd, d_lsz, d_lu};

    // Only loads carry WB_SEL_MEM, so the select field identifies them in flight
    always_comb begin
        ld_hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (vld_p[k] && ent_p[k].wb_sel == WB_SEL_MEM && ent_p[k].rd != '0 &&
                (ent_p[k].rd == rs1 || ent_p[k].rd == rs2))
                ld_hit = 1'b1;
        end
    end

    assign hazard   = in_valid & ld_hit;
    assign in_ready = ~stall & ~hazard & ~flush;
    assign accept   = in_valid & in_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic       vld_in;
        stage_ent_t ent_in;

        if (g == 0) begin : g_head
            assign vld_in = accept;
            assign ent_in = dec_ent;
        end else begin : g_body
            assign vld_in = vld_p[g-1];
            assign ent_in = ent_p[g-1];
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)
                vld_p[g] <= 1'b0;
            else if (flush)
                vld_p[g] <= 1'b0;
            else if (!stall)
                vld_p[g] <= vld_in;
        end

        // Payload is meaningless without its valid bit, so it carries no reset
        always_ff @(posedge clk) begin
            if (!stall)
                ent_p[g] <= ent_in;
        end
    end

    assign wb_valid    = vld_p[DEPTH-1];
    assign wb_sel      = wb_valid ? ent_p[DEPTH-1].wb_sel      : '0;
    assign rwe         = wb_valid ? ent_p[DEPTH-1].rwe         : 1'b0;
    assign csr_we      = wb_valid ? ent_p[DEPTH-1].csr_we      : 1'b0;
    assign illegal     = wb_valid ? ent_p[DEPTH-1].illegal     : 1'b0;
    assign wb_rd       = wb_valid ? ent_p[DEPTH-1].rd          : '0;
    assign ld_size     = wb_valid ? ent_p[DEPTH-1].ld_size     : '0;
    assign ld_unsigned = wb_valid ? ent_p[DEPTH-1].ld_unsigned : 1'b0;

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed and model-compared stimulus for wb_ctrl_pipe at DEPTH 1, 2, 4 and CSR_EN 0.
module tb_wb_ctrl_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, in_valid, stall, flush;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd, rs1, rs2;

    // instance 0: DEPTH 2, 1: DEPTH 2 CSR_EN 0, 2: DEPTH 1, 3: DEPTH 4
    logic       rdy [4], haz [4], wbv [4], rwe_o [4], csr_o [4], ill_o [4], lu_o [4];
    logic [1:0] sel_o [4], lsz_o [4];
    logic [4:0] rd_o [4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        wb_ctrl_pipe #(
            .DEPTH ((g == 2) ? 1 : (g == 3) ? 4 : 2),
            .CSR_EN((g == 1) ? 0 : 1)
        ) u_dut (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_valid   (in_valid),
            .in_ready   (rdy[g]),
            .stall      (stall),
            .flush      (flush),
            .opcode     (opcode),
            .funct3     (funct3),
            .rd         (rd),
            .rs1        (rs1),
            .rs2        (rs2),
            .wb_valid   (wbv[g]),
            .wb_sel     (sel_o[g]),
            .rwe        (rwe_o[g]),
            .csr_we     (csr_o[g]),
            .illegal    (ill_o[g]),
            .wb_rd      (rd_o[g]),
            .ld_size    (lsz_o[g]),
            .ld_unsigned(lu_o[g]),
            .hazard     (haz[g])
        );
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [6:0] op, input logic [2:0] f3,
                          input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
        in_valid = v;
        opcode   = op;
        funct3   = f3;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
    endtask

    typedef struct packed {
        logic [1:0] sel;
        logic       rwe;
        logic       csr;
        logic       ill;
        logic [4:0] rd;
        logic [1:0] lsz;
        logic       lu;
    } ment_t;

    function automatic ment_t ref_dec(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] d);
        ment_t e;
        e     = '0;
        e.sel = 2'd1;
        e.rd  = d;
        case (op)
            7'b0000011: begin e.sel = 2'd0; e.rwe = 1'b1; e.lsz = f3[1:0]; e.lu = f3[2]; end
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: e.rwe = 1'b1;
            7'b1101111, 7'b1100111: begin e.sel = 2'd2; e.rwe = 1'b1; end
            7'b1100011, 7'b0100011: begin end
            7'b1110011: if (f3 == 3'b001 || f3 == 3'b101) e.csr = 1'b1; else e.ill = 1'b1;
            default: e.ill = 1'b1;
        endcase
        if (d == 5'd0) e.rwe = 1'b0;
        return e;
    endfunction

    logic       mv [3][4];
    ment_t      me [3][4];
    int         mdep [3] = '{1, 2, 4};
    int         midx [3] = '{2, 0, 3};
    logic [6:0] ops [12] = '{7'b0000011, 7'b0000011, 7'b0110011, 7'b0010011, 7'b0110111,
                             7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0100011,
                             7'b1110011, 7'b1111111};

    localparam logic [6:0] LOAD = 7'b0000011, OP = 7'b0110011, OPIMM = 7'b0010011;
    localparam logic [6:0] SYS = 7'b1110011, JAL = 7'b1101111, LUI = 7'b0110111, AUIPC = 7'b0010111;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; flush = 1'b0;
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        #1;
        chk("rst_wbv", 32'(wbv[0]), 0);
        chk("rst_rwe", 32'(rwe_o[0]), 0);
        cyc(); cyc();
        chk("rst_ready", 32'(rdy[0]), 1);
        chk("rst_wbv_held", 32'(wbv[0]), 0);
        reset_n = 1'b1;

        // load latency and field decode
        set_in(1'b1, LOAD, 3'b100, 5'd5, 5'd1, 5'd2);
        #1;
        chk("t1_ready", 32'(rdy[0]), 1);
        cyc();
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        chk("t1_lat1_wbv", 32'(wbv[0]), 0);
        cyc();
        chk("t1_wbv", 32'(wbv[0]), 1);
        chk("t1_sel", 32'(sel_o[0]), 0);
        chk("t1_rwe", 32'(rwe_o[0]), 1);
        chk("t1_rd", 32'(rd_o[0]), 5);
        chk("t1_lsz", 32'(lsz_o[0]), 0);
        chk("t1_lu", 32'(lu_o[0]), 1);
        cyc();
        chk("t1_gone_wbv", 32'(wbv[0]), 0);
        chk("t1_gone_rwe", 32'(rwe_o[0]), 0);

        // load-use hazard
        set_in(1'b1, LOAD, 3'b010, 5'd7, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, OP, 3'd0, 5'd3, 5'd7, 5'd1);
        #1;
        chk("t2_haz_s0", 32'(haz[0]), 1);
        chk("t2_ready_s0", 32'(rdy[0]), 0);
        cyc();
        chk("t2_haz_s1", 32'(haz[0]), 1);
        chk("t2_ld_wbv", 32'(wbv[0]), 1);
        chk("t2_ld_rd", 32'(rd_o[0]), 7);
        chk("t2_ld_lsz", 32'(lsz_o[0]), 2);
        cyc();
        chk("t2_haz_clear", 32'(haz[0]), 0);
        chk("t2_ready", 32'(rdy[0]), 1);
        chk("t2_bubble1", 32'(wbv[0]), 0);
        cyc();
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        chk("t2_bubble2", 32'(wbv[0]), 0);
        cyc();
        chk("t2_op_wbv", 32'(wbv[0]), 1);
        chk("t2_op_rd", 32'(rd_o[0]), 3);
        chk("t2_op_sel", 32'(sel_o[0]), 1);
        chk("t2_op_rwe", 32'(rwe_o[0]), 1);

        // rd=0 write suppression and CSR decode
        set_in(1'b1, OPIMM, 3'd0, 5'd0, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, SYS, 3'b001, 5'd4, 5'd0, 5'd0);
        cyc();
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        chk("t3_opimm_wbv", 32'(wbv[0]), 1);
        chk("t3_opimm_rwe", 32'(rwe_o[0]), 0);
        chk("t3_opimm_csr", 32'(csr_o[0]), 0);
        chk("t3_opimm_ill", 32'(ill_o[0]), 0);
        cyc();
        chk("t3_sys_csr", 32'(csr_o[0]), 1);
        chk("t3_sys_rwe", 32'(rwe_o[0]), 0);
        chk("t3_sys_ill", 32'(ill_o[0]), 0);
        chk("t3_sys_sel", 32'(sel_o[0]), 1);
        chk("t3_nocsr_wbv", 32'(wbv[1]), 1);
        chk("t3_nocsr_ill", 32'(ill_o[1]), 1);
        chk("t3_nocsr_csr", 32'(csr_o[1]), 0);
        cyc();

        // load to x0 never blocks; rs2 alone triggers hazard
        set_in(1'b1, LOAD, 3'b010, 5'd0, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, OP, 3'd0, 5'd1, 5'd0, 5'd0);
        #1;
        chk("t3b_rd0_haz", 32'(haz[0]), 0);
        chk("t3b_rd0_ready", 32'(rdy[0]), 1);
        cyc();
        set_in(1'b1, LOAD, 3'b000, 5'd12, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, OP, 3'd0, 5'd2, 5'd1, 5'd12);
        #1;
        chk("t3b_rs2_haz", 32'(haz[0]), 1);
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        cyc(); cyc(); cyc();

        // stall hold, then flush over stall
        set_in(1'b1, JAL, 3'd0, 5'd1, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, LUI, 3'd0, 5'd2, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, AUIPC, 3'd0, 5'd9, 5'd0, 5'd0);
        stall = 1'b1;
        #1;
        chk("t4_stall_ready", 32'(rdy[0]), 0);
        chk("t4_jal_sel", 32'(sel_o[0]), 2);
        chk("t4_jal_rd", 32'(rd_o[0]), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t4_hold_wbv", 32'(wbv[0]), 1);
            chk("t4_hold_sel", 32'(sel_o[0]), 2);
            chk("t4_hold_rd", 32'(rd_o[0]), 1);
            chk("t4_hold_rwe", 32'(rwe_o[0]), 1);
        end
        flush = 1'b1;
        #1;
        chk("t4_flush_ready", 32'(rdy[0]), 0);
        cyc();
        chk("t4_flush_wbv", 32'(wbv[0]), 0);
        chk("t4_flush_rwe", 32'(rwe_o[0]), 0);
        flush = 1'b0; stall = 1'b0;
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t4_flush_s0", 32'(wbv[0]), 0);

        // illegal opcode, then reset mid-stream
        set_in(1'b1, 7'b1111111, 3'd0, 5'd6, 5'd0, 5'd0);
        cyc();
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        cyc();
        chk("t5_ill_wbv", 32'(wbv[0]), 1);
        chk("t5_ill", 32'(ill_o[0]), 1);
        chk("t5_ill_rwe", 32'(rwe_o[0]), 0);
        chk("t5_ill_sel", 32'(sel_o[0]), 1);
        cyc();
        set_in(1'b1, LOAD, 3'b101, 5'd8, 5'd0, 5'd0);
        cyc();
        set_in(1'b1, OP, 3'd0, 5'd9, 5'd0, 5'd0);
        cyc();
        set_in(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
        chk("t5_pre_rd", 32'(rd_o[0]), 8);
        reset_n = 1'b0;
        #1;
        chk("t5_arst_wbv", 32'(wbv[0]), 0);
        chk("t5_arst_rwe", 32'(rwe_o[0]), 0);
        chk("t5_arst_rd", 32'(rd_o[0]), 0);
        chk("t5_arst_lsz", 32'(lsz_o[0]), 0);
        chk("t5_arst_lu", 32'(lu_o[0]), 0);
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_post_wbv", 32'(wbv[0]), 0);
            chk("t5_post_rwe", 32'(rwe_o[0]), 0);
        end

        // random stream against a delay-line model at DEPTH 1, 2, 4
        reset_n = 1'b0;
        for (int k = 0; k < 3; k++)
            for (int j = 0; j < 4; j++) begin
                mv[k][j] = 1'b0;
                me[k][j] = '0;
            end
        cyc();
        reset_n = 1'b1;
        for (int c = 0; c < 240; c++) begin
            logic  m_hit, m_haz, m_rdy, acc;
            logic [15:0] exp_v, obs_v;
            int    t, ix;
            if (c < 220) begin
                in_valid = ($urandom_range(0, 9) < 8);
                stall    = ($urandom_range(0, 9) == 0);
                flush    = ($urandom_range(0, 29) == 0);
                opcode   = ops[$urandom_range(0, 11)];
                funct3   = 3'($urandom_range(0, 7));
                rd       = 5'($urandom_range(0, 7));
                rs1      = 5'($urandom_range(0, 7));
                rs2      = 5'($urandom_range(0, 7));
            end else begin
                in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                m_hit = 1'b0;
                for (int j = 0; j < mdep[k]; j++)
                    if (mv[k][j] && me[k][j].sel == 2'd0 && me[k][j].rd != 5'd0 &&
                        (me[k][j].rd == rs1 || me[k][j].rd == rs2))
                        m_hit = 1'b1;
                m_haz = in_valid & m_hit;
                m_rdy = ~stall & ~m_haz & ~flush;
                t     = mdep[k] - 1;
                ix    = midx[k];
                exp_v = {mv[k][t], mv[k][t] ? me[k][t] : 13'd0, m_haz, m_rdy};
                obs_v = {wbv[ix], sel_o[ix], rwe_o[ix], csr_o[ix], ill_o[ix], rd_o[ix],
                         lsz_o[ix], lu_o[ix], haz[ix], rdy[ix]};
                chk($sformatf("rand_d%0d_c%0d", mdep[k], c), 32'(obs_v), 32'(exp_v));
                acc = in_valid & m_rdy;
                if (flush) begin
                    for (int j = 0; j < 4; j++) mv[k][j] = 1'b0;
                end else if (!stall) begin
                    for (int j = 3; j > 0; j--) begin
                        mv[k][j] = mv[k][j-1];
                        me[k][j] = me[k][j-1];
                    end
                    mv[k][0] = acc;
                    me[k][0] = ref_dec(opcode, funct3, rd);
                end
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
